// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector.
// Holds the default geometry, the FSM state encoding and the deskew delay helper.
package psum_collector_pkg;

   // Default geometry: array columns, incoming lane width, accumulator width, rows per tile
   localparam int PC_ARRAY_COL = 4;
   localparam int PC_ACC_WIDTH = 16;
   localparam int PC_OUT_WIDTH = 32;
   localparam int PC_DEPTH     = 4;

   // Number of sideband flags carried alongside the data: {last, first, valid}
   localparam int PC_FLAG_W = 3;

   typedef enum logic [1:0] {
      PC_IDLE  = 2'd0,
      PC_ACCUM = 2'd1,
      PC_DRAIN = 2'd2
   } pc_state_e;

   // Delay applied to a lane so that every lane lines up with the most-lagging column.
   // Skewed lanes: lane n already lags by n cycles, so it needs max_dly-n more.
   // Unskewed lanes (flags): the full max_dly.
   function automatic int pc_lane_delay(input int max_dly, input int lane, input bit skewed);
      return skewed ? (max_dly - lane) : max_dly;
   endfunction

endpackage

// File: rtl/psum_collector_deskew.sv
// Per-lane delay line that realigns skewed systolic-array outputs.
// Lane gi is delayed by pc_lane_delay(MAX_DLY, gi, SKEWED) registers; zero delay is a wire.
module psum_deskew
   import psum_collector_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int LANE_W  = 16,
   parameter int MAX_DLY = 3,
   parameter bit SKEWED  = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [LANES*LANE_W-1:0]   i_data,
   output logic [LANES*LANE_W-1:0]   o_data
);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         localparam int DLY = pc_lane_delay(MAX_DLY, gi, SKEWED);
         if (DLY == 0) begin : g_wire
            assign o_data[gi*LANE_W +: LANE_W] = i_data[gi*LANE_W +: LANE_W];
         end else begin : g_pipe
            logic [LANE_W-1:0] r_pipe [DLY];
            // Shift register: shifts every cycle regardless of collector state
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  for (int i = 0; i < DLY; i++) r_pipe[i] <= '0;
               end else begin
                  r_pipe[0] <= i_data[gi*LANE_W +: LANE_W];
                  for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
               end
            end
            assign o_data[gi*LANE_W +: LANE_W] = r_pipe[DLY-1];
         end
      end
   endgenerate

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector: deskews systolic-array column outputs, accumulates K-tiles
// into a DEPTH-row buffer and drains finished rows over valid/ready.
// Optional macro PSUM_SAT_EN: accumulation saturates to the signed OUT_WIDTH range
// instead of wrapping. First-tile overwrite is unaffected either way.
// DEPTH must be a power of two >= 2 so the row pointers wrap naturally.
module psum_collector
   import psum_collector_pkg::*;
#(
   parameter int ARRAY_COL = PC_ARRAY_COL,
   parameter int ACC_WIDTH = PC_ACC_WIDTH,
   parameter int OUT_WIDTH = PC_OUT_WIDTH,
   parameter int DEPTH     = PC_DEPTH,
   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic                           in_tile_first,
   input  logic                           in_tile_last,
   input  logic [ARRAY_COL*ACC_WIDTH-1:0] in_psum_vec,
   output logic                           busy,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ARRAY_COL*OUT_WIDTH-1:0] out_vec,
   output logic [IDX_W-1:0]               out_row_idx,
   output logic                           err_overrun
);

   localparam int ROW_W = ARRAY_COL * OUT_WIDTH;

   pc_state_e              r_state;
   logic [IDX_W-1:0]       r_wr_ptr;
   logic [IDX_W-1:0]       r_rd_ptr;
   logic                   r_busy;
   logic                   r_out_valid;
   logic [ROW_W-1:0]       r_out_vec;
   logic [IDX_W-1:0]       r_out_row_idx;
   logic                   r_err_overrun;
   logic [ROW_W-1:0]       r_buf [DEPTH];

   logic [ARRAY_COL*ACC_WIDTH-1:0] w_a_row;
   logic [PC_FLAG_W-1:0]           w_a_flags;
   logic                           w_in_gated;
   logic                           w_a_valid;
   logic                           w_a_first;
   logic                           w_a_last;
   logic [ROW_W-1:0]               w_new_row;
   logic [ROW_W-1:0]               w_old_row;
   logic [IDX_W-1:0]               w_rd_next;

   // Samples arriving while draining are dropped before they enter the deskew pipe
   assign w_in_gated = in_valid & ~r_busy;

   psum_deskew #(
      .LANES   (ARRAY_COL),
      .LANE_W  (ACC_WIDTH),
      .MAX_DLY (ARRAY_COL - 1),
      .SKEWED  (1'b1)
   ) u_deskew_data (
      .clk    (clk),
      .rst    (rst),
      .i_data (in_psum_vec),
      .o_data (w_a_row)
   );

   psum_deskew #(
      .LANES   (1),
      .LANE_W  (PC_FLAG_W),
      .MAX_DLY (ARRAY_COL - 1),
      .SKEWED  (1'b0)
   ) u_deskew_flags (
      .clk    (clk),
      .rst    (rst),
      .i_data ({in_tile_last, in_tile_first, w_in_gated}),
      .o_data (w_a_flags)
   );

   assign w_a_valid = w_a_flags[0];
   assign w_a_first = w_a_flags[1];
   assign w_a_last  = w_a_flags[2];
   assign w_old_row = r_buf[r_wr_ptr];
   assign w_rd_next = r_rd_ptr + 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < ARRAY_COL; gi++) begin : g_acc
         logic signed [ACC_WIDTH-1:0] w_lane_in;
         logic signed [OUT_WIDTH-1:0] w_lane_ext;
         logic signed [OUT_WIDTH-1:0] w_lane_old;
         logic        [OUT_WIDTH-1:0] w_lane_sum;

         assign w_lane_in  = w_a_row[gi*ACC_WIDTH +: ACC_WIDTH];
         assign w_lane_ext = OUT_WIDTH'(w_lane_in);
         assign w_lane_old = w_old_row[gi*OUT_WIDTH +: OUT_WIDTH];
`ifdef PSUM_SAT_EN
         // One extra bit exposes signed overflow: top two bits disagree
         logic [OUT_WIDTH:0] w_lane_wide;
         assign w_lane_wide = {w_lane_old[OUT_WIDTH-1], w_lane_old}
                            + {w_lane_ext[OUT_WIDTH-1], w_lane_ext};
         assign w_lane_sum  = (w_lane_wide[OUT_WIDTH] != w_lane_wide[OUT_WIDTH-1])
                            ? (w_lane_wide[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}})
                            : w_lane_wide[OUT_WIDTH-1:0];
`else
         assign w_lane_sum  = w_lane_old + w_lane_ext;
`endif
         assign w_new_row[gi*OUT_WIDTH +: OUT_WIDTH] = w_a_first ? w_lane_ext : w_lane_sum;
      end
   endgenerate

   // Row buffer: first tile overwrites, later tiles accumulate into the addressed row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      end else if (w_a_valid) begin
         r_buf[r_wr_ptr] <= w_new_row;
      end
   end

   // Control FSM: collect tiles, then hand out DEPTH rows with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= PC_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_busy        <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_vec     <= '0;
         r_out_row_idx <= '0;
      end else begin
         if (w_a_valid) r_wr_ptr <= r_wr_ptr + 1'b1;
         case (r_state)
            PC_IDLE, PC_ACCUM: begin
               if (w_a_valid && w_a_last && (r_wr_ptr == IDX_W'(DEPTH - 1))) begin
                  r_state  <= PC_DRAIN;
                  r_busy   <= 1'b1;
                  r_rd_ptr <= '0;
               end else if (w_a_valid) begin
                  r_state <= PC_ACCUM;
               end
            end
            PC_DRAIN: begin
               if (!r_out_valid) begin
                  // First drain cycle: present row 0, which was finalised on entry
                  r_out_valid   <= 1'b1;
                  r_out_vec     <= r_buf[r_rd_ptr];
                  r_out_row_idx <= r_rd_ptr;
               end else if (out_ready) begin
                  if (r_rd_ptr == IDX_W'(DEPTH - 1)) begin
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                     r_wr_ptr    <= '0;
                     r_rd_ptr    <= '0;
                     r_state     <= PC_IDLE;
                  end else begin
                     r_rd_ptr      <= w_rd_next;
                     r_out_vec     <= r_buf[w_rd_next];
                     r_out_row_idx <= w_rd_next;
                  end
               end
            end
            default: r_state <= PC_IDLE;
         endcase
      end
   end

   // Sticky overrun flag: upstream pushed while we were draining
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_err_overrun <= 1'b0;
      else if (in_valid && r_busy) r_err_overrun <= 1'b1;
   end

   assign busy        = r_busy;
   assign out_valid   = r_out_valid;
   assign out_vec     = r_out_vec;
   assign out_row_idx = r_out_row_idx;
   assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_psum_collector.sv
// Directed testbench for psum_collector. A 32-bit-accumulator instance carries the
// main checks; a 16-bit-accumulator instance shares its inputs for the overflow case.
module tb_psum_collector;

   localparam int AC = 4;
   localparam int AW = 16;
   localparam int OW = 32;
   localparam int DP = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_tile_first;
   logic              in_tile_last;
   logic [AC*AW-1:0]  in_psum_vec;
   logic              out_ready;

   logic              busy, out_valid, err_overrun;
   logic [AC*OW-1:0]  out_vec;
   logic [1:0]        out_row_idx;

   logic              busy16, out_valid16, err_overrun16;
   logic [AC*16-1:0]  out_vec16;
   logic [1:0]        out_row_idx16;

   psum_collector #(.ARRAY_COL(AC), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_tile_first(in_tile_first),
      .in_tile_last(in_tile_last), .in_psum_vec(in_psum_vec), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
      .out_row_idx(out_row_idx), .err_overrun(err_overrun)
   );

   psum_collector #(.ARRAY_COL(AC), .ACC_WIDTH(AW), .OUT_WIDTH(16), .DEPTH(DP)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_tile_first(in_tile_first),
      .in_tile_last(in_tile_last), .in_psum_vec(in_psum_vec), .busy(busy16),
      .out_valid(out_valid16), .out_ready(out_ready), .out_vec(out_vec16),
      .out_row_idx(out_row_idx16), .err_overrun(err_overrun16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Stimulus rows (unskewed) and captured results
   int stim_val [16][AC];
   bit stim_first [16];
   bit stim_last  [16];
   int n_stim;
   int last_row_cyc;
   int got_lane   [8][AC];
   int got_lane16 [8][AC];
   int got_idx    [8];
   int got_n;
   int first_valid_cyc;
   int stall_changes;
   int extra_valid;
   int sync_diffs;

   task automatic set_row(input int r, input bit f, input bit l, input int base, input int step);
      for (int c = 0; c < AC; c++) stim_val[r][c] = base + step * c;
      stim_first[r] = f;
      stim_last[r]  = l;
   endtask

   // Present rows with column c lagging column 0 by c cycles, as the array does
   task automatic drive_rows();
      int r;
      int lane;
      for (int t = 0; t < n_stim + AC - 1; t++) begin
         @(posedge clk); #1;
         in_valid      = (t < n_stim);
         in_tile_first = (t < n_stim) ? stim_first[t] : 1'b0;
         in_tile_last  = (t < n_stim) ? stim_last[t]  : 1'b0;
         if (t == n_stim - 1) last_row_cyc = cyc;
         for (int c = 0; c < AC; c++) begin
            r = t - c;
            lane = (r >= 0 && r < n_stim) ? stim_val[r][c] : 0;
            in_psum_vec[c*AW +: AW] = AW'(lane);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_tile_first = 1'b0; in_tile_last = 1'b0; in_psum_vec = '0;
   endtask

   // Gather accepted rows; mode 0 = ready always, mode 1 = ready 1,0,1,0...
   task automatic collect(input int n_rows, input int mode, input int pulse_at, input int tail);
      bit prev_stall;
      logic [AC*OW-1:0] prev_vec;
      logic [1:0] prev_idx;
      prev_stall = 1'b0; prev_vec = '0; prev_idx = '0;
      got_n = 0; first_valid_cyc = -1; stall_changes = 0; extra_valid = 0; sync_diffs = 0;
      for (int k = 0; k < 80 && got_n < n_rows; k++) begin
         @(posedge clk); #1;
         in_valid      = (k == pulse_at);
         in_tile_first = (k == pulse_at);
         in_psum_vec   = (k == pulse_at) ? {AC{16'd99}} : '0;
         if (prev_stall && (out_vec !== prev_vec || out_row_idx !== prev_idx || out_valid !== 1'b1))
            stall_changes++;
         if (out_valid16 !== out_valid || busy16 !== busy || out_row_idx16 !== out_row_idx ||
             err_overrun16 !== err_overrun)
            sync_diffs++;
         out_ready = (mode == 0) ? 1'b1 : (k % 2 == 0);
         if (out_valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_ready) begin
               for (int c = 0; c < AC; c++) begin
                  got_lane[got_n][c]   = $signed(out_vec[c*OW +: OW]);
                  got_lane16[got_n][c] = $signed(out_vec16[c*16 +: 16]);
               end
               got_idx[got_n] = int'(out_row_idx);
               $display("cycle %0d: row accepted idx=%0d lane0=%0d lane3=%0d",
                        cyc, got_idx[got_n], got_lane[got_n][0], got_lane[got_n][AC-1]);
               got_n++;
            end
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_vec = out_vec;
         prev_idx = out_row_idx;
      end
      in_valid = 1'b0; in_tile_first = 1'b0; in_psum_vec = '0;
      out_ready = 1'b1;
      for (int k = 0; k < tail; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) extra_valid++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_tile_first = 1'b0; in_tile_last = 1'b0; in_psum_vec = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      n_checks++; if (out_vec !== '0) begin n_fail++; $display("FAIL reset_out_vec got %h expected 0", out_vec); end
      n_checks++; if (out_row_idx !== 2'd0) begin n_fail++; $display("FAIL reset_row_idx got %0d expected 0", out_row_idx); end
      n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err_overrun); end
      rst = 1'b0;
   endtask

   task automatic test_single_tile();
      n_stim = 4;
      for (int m = 0; m < 4; m++) set_row(m, 1'b1, 1'b1, 10*m, 1);
      drive_rows();
      collect(4, 0, -1, 3);
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL single_rows got %0d expected 4", got_n); end
      n_checks++; if (first_valid_cyc - last_row_cyc !== AC + 1) begin
         n_fail++; $display("FAIL single_latency got %0d expected %0d", first_valid_cyc - last_row_cyc, AC + 1); end
      n_checks++; if (extra_valid !== 0) begin n_fail++; $display("FAIL single_extra got %0d expected 0", extra_valid); end
      for (int m = 0; m < got_n; m++) begin
         n_checks++; if (got_idx[m] !== m) begin n_fail++; $display("FAIL single_idx got %0d expected %0d", got_idx[m], m); end
         for (int c = 0; c < AC; c++) begin
            n_checks++;
            if (got_lane[m][c] !== 10*m + c) begin
               n_fail++; $display("FAIL single_val row %0d lane %0d got %0d expected %0d", m, c, got_lane[m][c], 10*m + c);
            end
         end
      end
   endtask

   task automatic test_two_tiles();
      n_stim = 8;
      for (int m = 0; m < 4; m++) begin
         set_row(m,     1'b1, 1'b0, 10*m, 1);
         set_row(m + 4, 1'b0, 1'b1, 10*m, 1);
      end
      drive_rows();
      collect(4, 0, -1, 2);
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL two_rows got %0d expected 4", got_n); end
      for (int m = 0; m < got_n; m++)
         for (int c = 0; c < AC; c++) begin
            n_checks++;
            if (got_lane[m][c] !== 2*(10*m + c)) begin
               n_fail++; $display("FAIL two_val row %0d lane %0d got %0d expected %0d", m, c, got_lane[m][c], 2*(10*m + c));
            end
         end
   endtask

   task automatic test_negative();
      n_stim = 8;
      for (int m = 0; m < 4; m++) begin
         set_row(m,     1'b1, 1'b0, -5, 0);
         set_row(m + 4, 1'b0, 1'b1,  3, 0);
      end
      drive_rows();
      collect(4, 0, -1, 2);
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL neg_rows got %0d expected 4", got_n); end
      for (int m = 0; m < got_n; m++)
         for (int c = 0; c < AC; c++) begin
            n_checks++;
            if (got_lane[m][c] !== -2) begin
               n_fail++; $display("FAIL neg_val row %0d lane %0d got %0d expected -2", m, c, got_lane[m][c]);
            end
         end
   endtask

   task automatic test_backpressure();
      n_stim = 4;
      for (int m = 0; m < 4; m++) set_row(m, 1'b1, 1'b1, 100 + 10*m, 1);
      drive_rows();
      collect(4, 1, -1, 3);
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL bp_rows got %0d expected 4", got_n); end
      n_checks++; if (stall_changes !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes expected 0", stall_changes); end
      n_checks++; if (extra_valid !== 0) begin n_fail++; $display("FAIL bp_extra got %0d expected 0", extra_valid); end
      for (int m = 0; m < got_n; m++) begin
         n_checks++; if (got_idx[m] !== m) begin n_fail++; $display("FAIL bp_idx got %0d expected %0d", got_idx[m], m); end
         n_checks++;
         if (got_lane[m][2] !== 100 + 10*m + 2) begin
            n_fail++; $display("FAIL bp_val row %0d got %0d expected %0d", m, got_lane[m][2], 100 + 10*m + 2);
         end
      end
   endtask

   task automatic test_overflow();
      int exp16;
`ifdef PSUM_SAT_EN
      exp16 = 32767;
`else
      exp16 = -5536;
`endif
      n_stim = 8;
      for (int m = 0; m < 4; m++) begin
         set_row(m,     1'b1, 1'b0, 30000, 0);
         set_row(m + 4, 1'b0, 1'b1, 30000, 0);
      end
      drive_rows();
      collect(4, 0, -1, 2);
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL ovf_rows got %0d expected 4", got_n); end
      n_checks++; if (sync_diffs !== 0) begin n_fail++; $display("FAIL ovf_sync got %0d expected 0", sync_diffs); end
      for (int m = 0; m < got_n; m++) begin
         n_checks++;
         if (got_lane16[m][1] !== exp16) begin
            n_fail++; $display("FAIL ovf_w16 row %0d got %0d expected %0d", m, got_lane16[m][1], exp16);
         end
         n_checks++;
         if (got_lane[m][1] !== 60000) begin
            n_fail++; $display("FAIL ovf_w32 row %0d got %0d expected 60000", m, got_lane[m][1]);
         end
      end
   endtask

   task automatic test_overrun();
      n_stim = 4;
      for (int m = 0; m < 4; m++) set_row(m, 1'b1, 1'b1, 10*m, 1);
      drive_rows();
      collect(4, 0, 1, 6);
      n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_err got %b expected 1", err_overrun); end
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL overrun_rows got %0d expected 4", got_n); end
      for (int m = 0; m < got_n; m++) begin
         n_checks++;
         if (got_lane[m][3] !== 10*m + 3) begin
            n_fail++; $display("FAIL overrun_val row %0d got %0d expected %0d", m, got_lane[m][3], 10*m + 3);
         end
      end
      // A dropped sample must not disturb the next tile
      for (int m = 0; m < 4; m++) set_row(m, 1'b1, 1'b1, 5*m, 1);
      drive_rows();
      collect(4, 0, -1, 2);
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL post_overrun_rows got %0d expected 4", got_n); end
      for (int m = 0; m < got_n; m++) begin
         n_checks++;
         if (got_lane[m][0] !== 5*m || got_idx[m] !== m) begin
            n_fail++; $display("FAIL post_overrun_val row %0d got %0d idx %0d expected %0d idx %0d",
                               m, got_lane[m][0], got_idx[m], 5*m, m);
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      n_stim = 4;
      for (int m = 0; m < 4; m++) set_row(m, 1'b1, 1'b1, 10*m, 1);
      drive_rows();
      collect(2, 0, -1, 0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b expected 1", busy); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b expected 0", out_valid); end
      n_checks++; if (out_vec !== '0) begin n_fail++; $display("FAIL mid_rst_vec got %h expected 0", out_vec); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b expected 0", busy); end
      n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err got %b expected 0", err_overrun); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int m = 0; m < 4; m++) set_row(m, 1'b1, 1'b1, 20*m, 2);
      drive_rows();
      collect(4, 0, -1, 2);
      n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL after_rst_rows got %0d expected 4", got_n); end
      for (int m = 0; m < got_n; m++) begin
         n_checks++; if (got_idx[m] !== m) begin n_fail++; $display("FAIL after_rst_idx got %0d expected %0d", got_idx[m], m); end
         for (int c = 0; c < AC; c++) begin
            n_checks++;
            if (got_lane[m][c] !== 20*m + 2*c) begin
               n_fail++; $display("FAIL after_rst_val row %0d lane %0d got %0d expected %0d", m, c, got_lane[m][c], 20*m + 2*c);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_two_tiles();
      test_negative();
      test_backpressure();
      test_overflow();
      test_overrun();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits directly downstream of systolic_array and consumes out_psum_vec.
- Removes the per-column output skew and accumulates partial sums across K-tiles into a DEPTH-row buffer.
- After the last tile, drains finished rows to the next stage over a valid/ready handshake.

Parameters:
- ARRAY_COL, `ARRAY_COL: number of array columns (from params.vh).
- ACC_WIDTH, `ACC_WIDTH: width of each psum lane coming from the array.
- OUT_WIDTH, 32: accumulator and output lane width, signed; must be >= ACC_WIDTH.
- DEPTH, 4: output rows per tile, i.e. buffer entries; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  column-0 row of in_psum_vec is valid this cycle.
- in_tile_first  in  1  sideband with in_valid: overwrite instead of accumulate.
- in_tile_last  in  1  sideband with in_valid: this tile completes the result.
- in_psum_vec  in  ARRAY_COL*ACC_WIDTH  array outputs; column c lags column 0 by c cycles.
- busy  out  1  high in DRAIN; upstream must not assert in_valid.
- out_valid  out  1  out_vec holds a finished row.
- out_ready  in  1  downstream accepts the row.
- out_vec  out  ARRAY_COL*OUT_WIDTH  finished row.
- out_row_idx  out  $clog2(DEPTH)  index of the row on out_vec.
- err_overrun  out  1  sticky; in_valid was seen while busy.

Behaviour:
- Reset: busy=0, out_valid=0, out_vec=0, out_row_idx=0, err_overrun=0. Deskew pipes, row pointer, buffer and FSM all clear; state IDLE.
- Reset asserted mid-operation aborts immediately; no partial output is produced.
- All psum lanes are signed two's complement. Each lane is sign-extended to OUT_WIDTH before it is added.
- Deskew:
  - Column c passes through ARRAY_COL-1-c registers.
  - in_valid, in_tile_first and in_tile_last pass through ARRAY_COL-1 registers.
  - Result: an aligned row and aligned flags (a_valid, a_first, a_last).
  - Deskew pipes keep shifting in every state so in-flight data is never lost.
- Row pointer wr_ptr:
  - Increments on each a_valid; wraps DEPTH-1 -> 0.
  - On a_valid, entry wr_ptr is written at the next edge:
    - a_first=1: buf = aligned row.
    - a_first=0: buf = buf + aligned row.
- FSM states:
  - IDLE -> ACCUM on the first a_valid.
  - ACCUM: a_valid with a_last=1 and wr_ptr==DEPTH-1 -> DRAIN. Otherwise stay.
  - DRAIN:
    - busy=1. rd_ptr starts at 0.
    - out_valid rises one cycle after entry, with out_vec=buf[0] and out_row_idx=0.
    - On out_valid && out_ready, rd_ptr advances and the next row is registered with no bubble.
    - After row DEPTH-1 is accepted: out_valid=0, busy=0, wr_ptr=0, state IDLE.
- out_vec and out_row_idx stay stable while out_valid && !out_ready.
- in_valid while busy=1: the sample is dropped at the deskew input and err_overrun is set. err_overrun clears only on rst.
- Latency, single tile: last input row at cycle T gives first out_valid at T+ARRAY_COL+1.
- Flag errors are not checked. a_first and a_last together form a single-tile result.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: each accumulate saturates to the signed OUT_WIDTH range, i.e. -2^(OUT_WIDTH-1) .. 2^(OUT_WIDTH-1)-1.
- Undefined: accumulate wraps modulo 2^OUT_WIDTH.
- The first-tile overwrite is unaffected in both cases.

Decomposition:
- Add to params.vh:
  - OUT_WIDTH default.
  - FSM state encodings PC_IDLE=2'd0, PC_ACCUM=2'd1, PC_DRAIN=2'd2.
- Sub-module psum_deskew: parameterized per-column delay line. Instantiated once for data and once (width 3) for the flags.

Test Plan:
- Single tile, DEPTH=4: skewed row m, column c = 10*m+c, first=last=1 -> 4 outputs with out_vec[c]=10*m+c and out_row_idx 0,1,2,3, with out_ready held 1.
- Two tiles of the same data (first on tile 0, last on tile 1) -> outputs 2*(10*m+c). Negative case: -5 then +3 -> -2.
- Backpressure: out_ready pattern 1,0,1,0,... -> each row is delivered exactly once and in order, and out_vec is unchanged across stalled cycles.
- Overflow with OUT_WIDTH=16: 30000 + 30000 -> 32767 with PSUM_SAT_EN, -5536 without.
- in_valid pulsed during DRAIN -> err_overrun=1 and drained values match the no-pulse run.
- rst asserted mid-DRAIN, then a new single tile -> outputs zero immediately, then a correct full drain with rows 0..3.
